stump_reg_bank: RTL and testbench

STUMP_REG_BANK -- requirements
Module: Stump_reg_bank

---
 rtl/stump_reg_bank_pkg.sv | 19 +
 rtl/stump_reg_bank_if.sv | 29 ++
 rtl/stump_reg_bank_reg16.sv | 35 +++
 rtl/stump_reg_bank.sv | 58 +++++
 tb/tb_stump_reg_bank.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/stump_reg_bank_pkg.sv
// Shared constants and types for the Stump register bank: word width,
// register count, PC index and the index/word types used on every port.
package stump_reg_bank_pkg;

  localparam int WORD_W    = 16;
  localparam int REG_COUNT = 8;
  localparam int IDX_W     = 3;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  reg_idx_t;

  localparam reg_idx_t PC_IDX = 3'd7;

  // Next program counter value; the add wraps naturally at 2^16.
  function automatic word_t pc_next(input word_t pc_now);
    return pc_now + word_t'(1);
  endfunction

endpackage

// File: rtl/stump_reg_bank_if.sv
// Control/data bundle between the Stump datapath/control and the register
// bank. The master drives indices, write data and strobes; the slave (the
// bank) returns the three read ports and the program counter.
interface stump_reg_bank_if;
  import stump_reg_bank_pkg::*;

  logic     pc_inc;
  logic     write_en;
  reg_idx_t dest;
  word_t    write_data;
  reg_idx_t srcA;
  reg_idx_t srcB;
  reg_idx_t srcC;
  word_t    regA;
  word_t    regB;
  word_t    regC;
  word_t    pc;

  modport master (
    output pc_inc, write_en, dest, write_data, srcA, srcB, srcC,
    input  regA, regB, regC, pc
  );

  modport slave (
    input  pc_inc, write_en, dest, write_data, srcA, srcB, srcC,
    output regA, regB, regC, pc
  );

endinterface

// File: rtl/stump_reg_bank_reg16.sv
// One 16-bit storage register with synchronous reset and a load enable.
// The choice of what to load is made by the caller.
module stump_reg_bank_reg16
  import stump_reg_bank_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  word_t d,
  output word_t q
);

  word_t q_d;
  word_t q_q;

  // Take the new value only when loading, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end
  end

  // Register update; reset wins over any load on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/stump_reg_bank.sv
// Stump register bank: R1..R7 are real storage, R0 is hard-wired to zero.
// R7 doubles as the program counter and can be incremented by the fetch
// strobe; an explicit write to R7 on the same edge takes priority over the
// increment. Reads are purely combinational from the stored values, so a
// write only becomes visible after the clock edge that performs it.
module stump_reg_bank
  import stump_reg_bank_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  stump_reg_bank_if.slave  bus
);

  logic  load_en   [1:REG_COUNT-1];
  word_t load_data [1:REG_COUNT-1];
  word_t reg_q     [1:REG_COUNT-1];
  word_t read_view [0:REG_COUNT-1];
  logic  pc_written;

  // Work out which registers load this edge and with what. Only the
  // write/increment controls feed this, so garbage on the read indices can
  // never disturb storage.
  always_comb begin
    pc_written = bus.write_en && (bus.dest == PC_IDX);
    for (int i = 1; i < REG_COUNT; i++) begin
      load_en[i]   = bus.write_en && (bus.dest == reg_idx_t'(i));
      load_data[i] = bus.write_data;
    end
    if (bus.pc_inc && !pc_written) begin
      load_en[PC_IDX]   = 1'b1;
      load_data[PC_IDX] = pc_next(reg_q[PC_IDX]);
    end
  end

  for (genvar g = 1; g < REG_COUNT; g++) begin : g_regs
    stump_reg_bank_reg16 u_reg (
      .clk  (clk),
      .rst  (rst),
      .load (load_en[g]),
      .d    (load_data[g]),
      .q    (reg_q[g])
    );
  end

  // Flat read view with R0 fixed at zero, indexed by the three read ports.
  always_comb begin
    read_view[0] = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      read_view[i] = reg_q[i];
    end
  end

  assign bus.regA = read_view[bus.srcA];
  assign bus.regB = read_view[bus.srcB];
  assign bus.regC = read_view[bus.srcC];
  assign bus.pc   = reg_q[PC_IDX];

endmodule

// File: tb/tb_stump_reg_bank.sv
// Directed self-checking bench for the Stump register bank.
module tb_stump_reg_bank;
  import stump_reg_bank_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  stump_reg_bank_if bus ();

  stump_reg_bank u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running 10 time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Set up the control inputs for the next edge.
  task automatic applyStimulus(input logic r, input logic inc, input logic we,
                               input reg_idx_t d, input word_t data);
    rst            = r;
    bus.pc_inc     = inc;
    bus.write_en   = we;
    bus.dest       = d;
    bus.write_data = data;
  endtask

  // Take one rising edge, then return controls to idle a little after it.
  task automatic clockEdge();
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.write_en = 1'b0;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input word_t observed,
                             input word_t expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Read register idx through port A.
  task automatic checkReg(input string tag, input reg_idx_t idx,
                          input word_t expected);
    bus.srcA = idx;
    #1;
    checkOutput(tag, bus.regA, expected);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.srcA = '0;
    bus.srcB = '0;
    bus.srcC = '0;

    // Reset edge, then read back PC and two ordinary registers.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
    clockEdge();
    bus.srcA = 3'd7;
    bus.srcB = 3'd3;
    #1;
    checkOutput("reset_pc", bus.pc, 16'h0000);
    checkOutput("reset_regA_r7", bus.regA, 16'h0000);
    checkOutput("reset_regB_r3", bus.regB, 16'h0000);

    // Write R3 and confirm it is not visible before the edge.
    bus.srcA = 3'd3;
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3, 16'hA5A5);
    #1;
    checkOutput("r3_no_bypass", bus.regA, 16'h0000);
    clockEdge();
    bus.srcB = 3'd0;
    #1;
    checkOutput("r3_after_write", bus.regA, 16'hA5A5);
    checkOutput("r0_reads_zero", bus.regB, 16'h0000);

    // Writes to R0 are discarded.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 16'h1234);
    clockEdge();
    checkReg("r0_write_discarded", 3'd0, 16'h0000);
    checkReg("r3_kept_after_r0_write", 3'd3, 16'hA5A5);

    // Idle edge with a wild read index: state must hold.
    bus.srcA = 3'bxxx;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd3, 16'hFFFF);
    clockEdge();
    checkReg("r3_hold_idle", 3'd3, 16'hA5A5);
    checkOutput("pc_hold_idle", bus.pc, 16'h0000);

    // Three fetch strobes from reset give PC=3.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
    clockEdge();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 16'h0000);
      clockEdge();
    end
    checkOutput("pc_after_3_inc", bus.pc, 16'h0003);
    checkReg("r3_cleared_by_reset", 3'd3, 16'h0000);

    // Load PC with all ones and let it wrap.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd7, 16'hFFFF);
    clockEdge();
    checkOutput("pc_loaded_ffff", bus.pc, 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 16'h0000);
    clockEdge();
    checkOutput("pc_wrap", bus.pc, 16'h0000);

    // Write to R7 beats the increment on the same edge.
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd7, 16'h0040);
    clockEdge();
    checkOutput("pc_write_wins", bus.pc, 16'h0040);

    // Write to another register and increment both happen.
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd2, 16'h0009);
    clockEdge();
    checkReg("r2_with_inc", 3'd2, 16'h0009);
    checkOutput("pc_inc_with_r2_write", bus.pc, 16'h0041);
    checkReg("r7_via_port_a", 3'd7, 16'h0041);

    // Port C shows the old R5 during the write cycle, new value after.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd5, 16'h1111);
    clockEdge();
    bus.srcC = 3'd5;
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd5, 16'h7777);
    #1;
    checkOutput("regC_old_value", bus.regC, 16'h1111);
    clockEdge();
    checkOutput("regC_new_value", bus.regC, 16'h7777);

    // Reset overrides a coincident write and increment.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd4, 16'h4444);
    clockEdge();
    checkReg("r4_before_reset", 3'd4, 16'h4444);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd4, 16'hBEEF);
    clockEdge();
    checkReg("r4_reset_override", 3'd4, 16'h0000);
    checkOutput("pc_reset_override", bus.pc, 16'h0000);
    checkOutput("regC_r5_reset", bus.regC, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
